rom_prefetch: RTL and testbench

- Byte-stream fetch stage between the 64x8 program ROM and the CPU core's instruction decoder.
- Drives the ROM address and absorbs its one-cycle registered read latency.
- Buffers sequential bytes in a small FIFO and presents them to the core through a valid/ready handshake, each tagged with its address.
- Supports a jump/flush request so branch targets restart the stream without delivering stale bytes.

---
 rtl/rom_prefetch.sv | 126 ++++++++++++
 tb/tb_rom_prefetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_prefetch.sv
// rom_prefetch
//   Byte-stream fetch stage between the program ROM and the instruction
//   decoder. It drives the ROM address, absorbs the ROM's one-cycle
//   registered read latency, and buffers sequential bytes in a small FIFO.
//   Each byte is presented to the core through a valid/ready handshake,
//   tagged with the address it was read from. A jump request flushes
//   everything and restarts the stream at a new address.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   rom_address   ROM read address (always the current fetch address)
//   rom_data      ROM read data, valid one cycle after rom_address
//   jump          flush and restart fetching at jump_address
//   jump_address  restart address, sampled when jump=1
//   byte_out      FIFO head byte (0 when empty)
//   byte_pc       address of byte_out (0 when empty)
//   byte_valid    head entry is valid
//   byte_ready    core accepts the head entry when byte_valid=1
module rom_prefetch #(
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [7:0]            rom_data,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jump_address,
   output logic [7:0]            byte_out,
   output logic [ADDR_WIDTH-1:0] byte_pc,
   output logic                  byte_valid,
   input  logic                  byte_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_WIDTH-1:0] fetch_addr_r;
   logic                  in_flight_r;
   logic [ADDR_WIDTH-1:0] in_flight_addr_r;
   logic [7:0]            mem_byte_r [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc_r   [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [CNT_W-1:0]      count_r;

   logic [CNT_W:0]        occupancy_s;
   logic                  issue_s;
   logic                  push_s;
   logic                  pop_s;

   // Credit check on registered state only: a pop in this cycle does not
   // free a slot until next cycle, so a captured byte always has room.
   always_comb begin
      occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, in_flight_r};
      issue_s     = (occupancy_s < (CNT_W + 1)'(DEPTH));
      push_s      = in_flight_r;
      pop_s       = (count_r != {CNT_W{1'b0}}) && byte_ready;
   end

   // Fetch address, outstanding-read tracking and FIFO state.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_addr_r     <= {ADDR_WIDTH{1'b0}};
         in_flight_r      <= 1'b0;
         in_flight_addr_r <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r         <= {PTR_W{1'b0}};
         wr_ptr_r         <= {PTR_W{1'b0}};
         count_r          <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_byte_r[i] <= 8'h00;
            mem_pc_r[i]   <= {ADDR_WIDTH{1'b0}};
         end
      end else if (jump) begin
         // The read already in flight belongs to the old stream; drop it.
         fetch_addr_r <= jump_address;
         in_flight_r  <= 1'b0;
         rd_ptr_r     <= {PTR_W{1'b0}};
         wr_ptr_r     <= {PTR_W{1'b0}};
         count_r      <= {CNT_W{1'b0}};
      end else begin
         if (issue_s) begin
            in_flight_r      <= 1'b1;
            in_flight_addr_r <= fetch_addr_r;
            fetch_addr_r     <= fetch_addr_r + ADDR_WIDTH'(1);
         end else begin
            in_flight_r <= 1'b0;
         end

         if (push_s) begin
            mem_byte_r[wr_ptr_r] <= rom_data;
            mem_pc_r[wr_ptr_r]   <= in_flight_addr_r;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end

         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end

         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head presentation; outputs read as zero while the FIFO is empty.
   always_comb begin
      rom_address = fetch_addr_r;
      byte_valid  = (count_r != {CNT_W{1'b0}});
      if (byte_valid) begin
         byte_out = mem_byte_r[rd_ptr_r];
         byte_pc  = mem_pc_r[rd_ptr_r];
      end else begin
         byte_out = 8'h00;
         byte_pc  = {ADDR_WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_rom_prefetch.sv
// tb_rom_prefetch
//   Directed bench for rom_prefetch with a registered 64x8 ROM model
//   holding ROM[i] = i ^ 8'hA5.
module tb_rom_prefetch;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] rom_address;
   logic [7:0] rom_data;
   logic       jump;
   logic [5:0] jump_address;
   logic [7:0] byte_out;
   logic [5:0] byte_pc;
   logic       byte_valid;
   logic       byte_ready;

   logic [7:0] rom_mem [64];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rom_prefetch #(.ADDR_WIDTH(6), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .rom_address  (rom_address),
      .rom_data     (rom_data),
      .jump         (jump),
      .jump_address (jump_address),
      .byte_out     (byte_out),
      .byte_pc      (byte_pc),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready)
   );

   // Registered ROM: data for an address appears one cycle later.
   always_ff @(posedge clk) begin
      rom_data <= rom_mem[rom_address];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; everything is sampled and driven 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   // Collect nbytes accepted bytes starting at start_pc within budget cycles.
   task automatic expect_stream(input logic [5:0] start_pc, input int nbytes,
                                input int budget, input string tag);
      logic [5:0] exp_pc;
      int got;
      int cyc;
      exp_pc = start_pc;
      got = 0;
      cyc = 0;
      while (got < nbytes && cyc < budget) begin
         if (byte_valid && byte_ready) begin
            chk({tag, "_pc"},   32'(byte_pc),  32'(exp_pc));
            chk({tag, "_data"}, 32'(byte_out), 32'(rom_mem[exp_pc]));
            exp_pc = exp_pc + 6'd1;
            got++;
         end
         tick();
         cyc++;
      end
      if (got < nbytes) chk({tag, "_timeout"}, 32'(got), 32'(nbytes));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] exp_pc;
      logic [5:0] occ;

      for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
      jump = 1'b0;
      jump_address = 6'd0;
      byte_ready = 1'b1;

      // Reset latency and full-rate streaming.
      do_reset(2);
      chk("rst_addr",  32'(rom_address), 32'd0);
      chk("rst_valid", 32'(byte_valid),  32'd0);
      chk("rst_out",   32'(byte_out),    32'd0);
      chk("rst_pc",    32'(byte_pc),     32'd0);
      tick();
      chk("c1_valid",  32'(byte_valid),  32'd0);
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("tp_valid", 32'(byte_valid), 32'd1);
         chk("tp_pc",    32'(byte_pc),    32'(i));
         chk("tp_data",  32'(byte_out),   32'(8'(i) ^ 8'hA5));
         tick();
      end

      // Back-pressure: FIFO fills, fetch stops at head_pc + DEPTH.
      byte_ready = 1'b0;
      do_reset(2);
      repeat (10) tick();
      chk("bp_addr",  32'(rom_address), 32'd4);
      chk("bp_valid", 32'(byte_valid),  32'd1);
      chk("bp_pc",    32'(byte_pc),     32'd0);
      chk("bp_data",  32'(byte_out),    32'hA5);
      byte_ready = 1'b1;
      expect_stream(6'd0, 8, 24, "bp");

      // Jump while count=3 and a read is in flight (cycle 4 after reset).
      byte_ready = 1'b0;
      do_reset(2);
      repeat (4) tick();
      chk("pj_addr", 32'(rom_address), 32'd4);
      chk("pj_pc",   32'(byte_pc),     32'd0);
      byte_ready   = 1'b1;
      jump         = 1'b1;
      jump_address = 6'h30;
      tick();
      jump = 1'b0;
      chk("j_valid", 32'(byte_valid),  32'd0);
      chk("j_addr",  32'(rom_address), 32'h30);
      expect_stream(6'h30, 6, 14, "j30");

      // Jump near the top of the address space: 3E,3F,00,01.
      jump         = 1'b1;
      jump_address = 6'h3E;
      tick();
      jump = 1'b0;
      expect_stream(6'h3E, 4, 12, "wrap");

      // Back-to-back jumps: only the last target is fetched.
      jump         = 1'b1;
      jump_address = 6'h10;
      tick();
      jump_address = 6'h20;
      tick();
      jump = 1'b0;
      expect_stream(6'h20, 3, 12, "b2b");

      // Random back-pressure with a pc scoreboard and occupancy bound.
      jump         = 1'b1;
      jump_address = 6'h00;
      tick();
      jump = 1'b0;
      exp_pc = 6'd0;
      for (int c = 0; c < 200; c++) begin
         byte_ready = 1'($urandom_range(0, 1));
         if (byte_valid) begin
            occ = rom_address - byte_pc;
            chk("rnd_occ", 32'(occ <= 6'd4), 32'd1);
            if (byte_ready) begin
               chk("rnd_pc",   32'(byte_pc),  32'(exp_pc));
               chk("rnd_data", 32'(byte_out), 32'(rom_mem[exp_pc]));
               exp_pc = exp_pc + 6'd1;
            end
         end
         tick();
      end
      chk("rnd_progress", 32'(exp_pc != 6'd0), 32'd1);

      // Reset together with jump mid-stream: reset wins.
      byte_ready = 1'b1;
      expect_stream(exp_pc, 2, 12, "pre_rst");
      reset        = 1'b1;
      jump         = 1'b1;
      jump_address = 6'h15;
      tick();
      chk("rj_valid", 32'(byte_valid),  32'd0);
      chk("rj_addr",  32'(rom_address), 32'd0);
      reset = 1'b0;
      jump  = 1'b0;
      chk("rj_c0_addr", 32'(rom_address), 32'd0);
      tick();
      chk("rj_c1_valid", 32'(byte_valid), 32'd0);
      tick();
      chk("rj_c2_valid", 32'(byte_valid), 32'd1);
      chk("rj_c2_pc",    32'(byte_pc),    32'd0);
      chk("rj_c2_data",  32'(byte_out),   32'hA5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
